filled_circle: RTL and testbench

FILLED_CIRCLE -- requirements
Module: filled_circle

---
 rtl/gpu_pkg.sv | 22 ++
 rtl/span_walker.sv | 45 ++++
 rtl/filled_circle.sv | 207 ++++++++++++++++++++
 tb/tb_filled_circle.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared raster-engine constants and state encodings for the circle filler.
package gpu_pkg;

    localparam int WIDTH_BITS   = 10;
    localparam int HEIGHT_BITS  = 9;
    localparam int CHANNEL_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Order in which the four horizontal spans of one midpoint step are emitted.
    typedef enum logic [1:0] {
        SPAN_S0 = 2'd0,
        SPAN_S1 = 2'd1,
        SPAN_S2 = 2'd2,
        SPAN_S3 = 2'd3
    } span_t;

endpackage

// File: rtl/span_walker.sv
// Walks X from a left bound across 2*half+1 pixels, one per cycle, flagging the last.
module span_walker #(
    parameter int WIDTH_BITS = gpu_pkg::WIDTH_BITS
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load_i,
    input  logic [WIDTH_BITS-1:0] left_i,
    input  logic [WIDTH_BITS-1:0] half_i,
    input  logic                  step_i,
    output logic [WIDTH_BITS-1:0] x_o,
    output logic                  last_o
);

    logic [WIDTH_BITS-1:0] x_q, x_d;
    // Remaining-pixel count rather than a bound compare, so spans wider than
    // the X range still terminate correctly when X wraps.
    logic [WIDTH_BITS:0]   cnt_q, cnt_d;

    always_comb begin
        x_d   = x_q;
        cnt_d = cnt_q;
        if (load_i) begin
            x_d   = left_i;
            cnt_d = {half_i, 1'b0};
        end else if (step_i) begin
            x_d   = x_q + WIDTH_BITS'(1);
            cnt_d = cnt_q - (WIDTH_BITS + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q   <= '0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            cnt_q <= cnt_d;
        end
    end

    assign x_o    = x_q;
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/filled_circle.sv
// Filled-circle rasteriser: midpoint algorithm emitting four horizontal spans per step.
module filled_circle #(
    parameter int WIDTH_BITS   = gpu_pkg::WIDTH_BITS,
    parameter int HEIGHT_BITS  = gpu_pkg::HEIGHT_BITS,
    parameter int CHANNEL_BITS = gpu_pkg::CHANNEL_BITS
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [WIDTH_BITS-1:0]   xC,
    input  logic [HEIGHT_BITS-1:0]  yC,
    input  logic [WIDTH_BITS-1:0]   rad,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH_BITS-1:0]   X,
    output logic [HEIGHT_BITS-1:0]  Y,
    output logic [CHANNEL_BITS-1:0] r_o,
    output logic [CHANNEL_BITS-1:0] g_o,
    output logic [CHANNEL_BITS-1:0] b_o
);

    import gpu_pkg::*;

    localparam int CW = WIDTH_BITS + 3;

    typedef struct packed {
        logic [WIDTH_BITS-1:0]  left;
        logic [WIDTH_BITS-1:0]  half;
        logic [HEIGHT_BITS-1:0] row;
    } span_cfg_t;

    function automatic span_cfg_t span_cfg(input span_t                  s,
                                           input logic [WIDTH_BITS-1:0]  xc,
                                           input logic [HEIGHT_BITS-1:0] yc,
                                           input logic [WIDTH_BITS-1:0]  xv,
                                           input logic [WIDTH_BITS-1:0]  yv);
        span_cfg_t c;
        if (s == SPAN_S0 || s == SPAN_S1) begin
            c.left = xc - xv;
            c.half = xv;
        end else begin
            c.left = xc - yv;
            c.half = yv;
        end
        case (s)
            SPAN_S0: c.row = yc + yv[HEIGHT_BITS-1:0];
            SPAN_S1: c.row = yc - yv[HEIGHT_BITS-1:0];
            SPAN_S2: c.row = yc + xv[HEIGHT_BITS-1:0];
            default: c.row = yc - xv[HEIGHT_BITS-1:0];
        endcase
        return c;
    endfunction

    state_t                  state_q, state_d;
    span_t                   seg_q, seg_d;
    logic signed [CW-1:0]    x_q, x_d, y_q, y_d, d_q, d_d;
    logic signed [CW-1:0]    xn, yn, dn;
    logic [WIDTH_BITS-1:0]   xc_q, xc_d;
    logic [HEIGHT_BITS-1:0]  yc_q, yc_d;
    logic [CHANNEL_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [HEIGHT_BITS-1:0]  row_q, row_d;
    logic                    busy_q, busy_d, done_q, done_d;

    span_cfg_t               cfg;
    logic                    sw_load, sw_step, sw_last;
    logic [WIDTH_BITS-1:0]   sw_x;

    span_walker #(
        .WIDTH_BITS(WIDTH_BITS)
    ) u_span (
        .clk    (clk),
        .n_rst  (n_rst),
        .load_i (sw_load),
        .left_i (cfg.left),
        .half_i (cfg.half),
        .step_i (sw_step),
        .x_o    (sw_x),
        .last_o (sw_last)
    );

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        x_d     = x_q;
        y_d     = y_q;
        d_d     = d_q;
        xc_d    = xc_q;
        yc_d    = yc_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        row_d   = row_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sw_load = 1'b0;
        sw_step = 1'b0;
        cfg     = '0;

        // Midpoint step, evaluated every cycle so it is ready on the last S3 pixel.
        xn = x_q + CW'(1);
        if (d_q[CW-1]) begin
            dn = d_q + (x_q <<< 1) + CW'(3);
            yn = y_q;
        end else begin
            dn = d_q + ((x_q - y_q) <<< 1) + CW'(5);
            yn = y_q - CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    xc_d    = xC;
                    yc_d    = yC;
                    r_d     = r_i;
                    g_d     = g_i;
                    b_d     = b_i;
                    x_d     = '0;
                    y_d     = CW'(rad);
                    d_d     = CW'(1) - CW'(rad);
                    seg_d   = SPAN_S0;
                    cfg     = span_cfg(SPAN_S0, xC, yC, '0, rad);
                    sw_load = 1'b1;
                    row_d   = cfg.row;
                    busy_d  = 1'b1;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                busy_d = 1'b1;
                if (!sw_last) begin
                    sw_step = 1'b1;
                end else if (seg_q != SPAN_S3) begin
                    seg_d   = span_t'(seg_q + 2'd1);
                    cfg     = span_cfg(seg_d, xc_q, yc_q,
                                       x_q[WIDTH_BITS-1:0], y_q[WIDTH_BITS-1:0]);
                    sw_load = 1'b1;
                    row_d   = cfg.row;
                end else begin
                    x_d = xn;
                    y_d = yn;
                    d_d = dn;
                    if (xn <= yn) begin
                        seg_d   = SPAN_S0;
                        cfg     = span_cfg(SPAN_S0, xc_q, yc_q,
                                           xn[WIDTH_BITS-1:0], yn[WIDTH_BITS-1:0]);
                        sw_load = 1'b1;
                        row_d   = cfg.row;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            seg_q   <= SPAN_S0;
            x_q     <= '0;
            y_q     <= '0;
            d_q     <= '0;
            xc_q    <= '0;
            yc_q    <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            x_q     <= x_d;
            y_q     <= y_d;
            d_q     <= d_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign X    = sw_x;
    assign Y    = row_q;
    assign r_o  = r_q;
    assign g_o  = g_q;
    assign b_o  = b_q;

endmodule

// File: tb/tb_filled_circle.sv
// Scoreboard bench for filled_circle: expected pixels queued by the driver, checked by a monitor.
module tb_filled_circle;

    localparam int W = 10;
    localparam int H = 9;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [W-1:0] xC, rad;
    logic [H-1:0] yC;
    logic [C-1:0] r_i, g_i, b_i;
    logic         start;
    logic         busy, done;
    logic [W-1:0] X;
    logic [H-1:0] Y;
    logic [C-1:0] r_o, g_o, b_o;

    filled_circle #(
        .WIDTH_BITS  (W),
        .HEIGHT_BITS (H),
        .CHANNEL_BITS(C)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .xC   (xC),
        .yC   (yC),
        .rad  (rad),
        .r_i  (r_i),
        .g_i  (g_i),
        .b_i  (b_i),
        .start(start),
        .busy (busy),
        .done (done),
        .X    (X),
        .Y    (Y),
        .r_o  (r_o),
        .g_o  (g_o),
        .b_o  (b_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int r;
        int g;
        int b;
    } pix_t;

    pix_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    int   done_cyc = -1;
    bit   prev_busy = 1'b0;
    bit   geo_en    = 1'b0;
    bit   gap_en    = 1'b0;
    bit   cov [0:511][0:1023];

    function automatic int wrap(input int v, input int m);
        return ((v % m) + m) % m;
    endfunction

    task automatic push_pix(input int x, input int y, input int r, input int g, input int b);
        pix_t p;
        p.x = wrap(x, 1 << W);
        p.y = wrap(y, 1 << H);
        p.r = r;
        p.g = g;
        p.b = b;
        exp_q.push_back(p);
    endtask

    // Reference: integer midpoint circle, each step filled by four horizontal spans.
    task automatic model_circle(input int xc, input int yc, input int rr,
                                input int r, input int g, input int b);
        int x, y, d;
        x = 0;
        y = rr;
        d = 1 - rr;
        while (1) begin
            for (int i = -x; i <= x; i++) push_pix(xc + i, yc + y, r, g, b);
            for (int i = -x; i <= x; i++) push_pix(xc + i, yc - y, r, g, b);
            for (int i = -y; i <= y; i++) push_pix(xc + i, yc + x, r, g, b);
            for (int i = -y; i <= y; i++) push_pix(xc + i, yc - x, r, g, b);
            if (d < 0) begin
                d = d + 2 * x + 3;
            end else begin
                d = d + 2 * (x - y) + 5;
                y = y - 1;
            end
            x = x + 1;
            if (x > y) break;
        end
    endtask

    always @(posedge clk) begin
        pix_t p;
        int   dx, dy;
        #1;
        cyc++;
        if (busy) begin
            if (gap_en && !prev_busy && done_cyc >= 0) begin
                checks++;
                if (cyc - done_cyc != 2) begin
                    errors++;
                    $display("FAIL restart_gap got %0d cycles required 2", cyc - done_cyc);
                end
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pixel got X=%0d Y=%0d required no pixel", X, Y);
            end else begin
                p = exp_q.pop_front();
                if ({X, Y, r_o, g_o, b_o} !== {W'(p.x), H'(p.y), C'(p.r), C'(p.g), C'(p.b)}) begin
                    errors++;
                    $display("FAIL pixel got (%0d,%0d) %0d/%0d/%0d required (%0d,%0d) %0d/%0d/%0d",
                             X, Y, r_o, g_o, b_o, p.x, p.y, p.r, p.g, p.b);
                end
            end
            if (geo_en) begin
                dx = int'(X) - 320;
                dy = int'(Y) - 240;
                checks++;
                if (dx * dx + dy * dy > 100 * 100 + 100) begin
                    errors++;
                    $display("FAIL geometry got (%0d,%0d) dist2=%0d required <= 10100", X, Y, dx*dx + dy*dy);
                end
                cov[Y][X] = 1'b1;
            end
        end
        if (done) begin
            checks++;
            done_cnt++;
            done_cyc = cyc;
            if (busy || !prev_busy || exp_q.size() != 0) begin
                errors++;
                $display("FAIL done_pulse got busy=%0d prev_busy=%0d pending=%0d required 0/1/0",
                         busy, prev_busy, exp_q.size());
            end
        end
        prev_busy = busy;
    end

    task automatic check_zero(input string name);
        checks++;
        if ({busy, done, X, Y, r_o, g_o, b_o} !== '0) begin
            errors++;
            $display("FAIL %s got busy=%0d done=%0d X=%0d Y=%0d rgb=%0d/%0d/%0d required all 0",
                     name, busy, done, X, Y, r_o, g_o, b_o);
        end
    endtask

    task automatic start_draw(input int xc, input int yc, input int rr,
                              input int r, input int g, input int b);
        @(negedge clk);
        xC    = W'(xc);
        yC    = H'(yc);
        rad   = W'(rr);
        r_i   = C'(r);
        g_i   = C'(g);
        b_i   = C'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        xC    = W'($urandom);
        yC    = H'($urandom);
        rad   = W'($urandom);
        r_i   = C'($urandom);
        g_i   = C'($urandom);
        b_i   = C'($urandom);
    endtask

    task automatic wait_done(input string name, input int n_done, input bit pulse_start);
        int d0, budget;
        d0     = done_cnt;
        budget = exp_q.size() + 20;
        for (int i = 0; i < budget && done_cnt < d0 + n_done; i++) begin
            @(negedge clk);
            if (pulse_start && i == 2 && exp_q.size() > 6) start = 1'b1;
            else if (pulse_start) start = 1'b0;
        end
        if (pulse_start) start = 1'b0;
        checks++;
        if (done_cnt != d0 + n_done) begin
            errors++;
            $display("FAIL %s_done got %0d done pulses required %0d", name, done_cnt - d0, n_done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_count got %0d pixels missing required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int xc, yc, rr, r, g, b;
        int mn, mx, cnt;
        n_rst = 1'b0;
        start = 1'b0;
        xC = '0; yC = '0; rad = '0;
        r_i = '0; g_i = '0; b_i = '0;
        @(negedge clk);
        check_zero("reset_state");
        n_rst = 1'b1;
        repeat (6) @(negedge clk);
        check_zero("idle_after_reset");

        // rad = 0: four copies of the centre pixel
        for (int i = 0; i < 4; i++) push_pix(100, 50, 255, 0, 17);
        start_draw(100, 50, 0, 255, 0, 17);
        wait_done("rad0", 1, 1'b0);

        // rad = 1: explicit pixel order
        push_pix(10, 11, 1, 2, 3);
        push_pix(10, 9, 1, 2, 3);
        for (int k = 0; k < 2; k++)
            for (int i = 9; i <= 11; i++) push_pix(i, 10, 1, 2, 3);
        start_draw(10, 10, 1, 1, 2, 3);
        wait_done("rad1", 1, 1'b0);

        // randomized draws including X/Y wrap and a mid-draw start pulse
        for (int t = 0; t < 8; t++) begin
            xc = int'($urandom_range(0, 1023));
            yc = int'($urandom_range(0, 511));
            rr = int'($urandom_range(0, 24));
            r  = int'($urandom_range(0, 255));
            g  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            model_circle(xc, yc, rr, r, g, b);
            start_draw(xc, yc, rr, r, g, b);
            wait_done("random", 1, 1'b1);
        end

        // large circle: geometric bound and contiguous row coverage
        for (int yy = 0; yy < 512; yy++)
            for (int xx = 0; xx < 1024; xx++) cov[yy][xx] = 1'b0;
        geo_en = 1'b1;
        model_circle(320, 240, 100, 255, 255, 255);
        start_draw(320, 240, 100, 255, 255, 255);
        wait_done("big", 1, 1'b0);
        geo_en = 1'b0;
        for (int yy = 0; yy < 512; yy++) begin
            mn = 1024; mx = -1; cnt = 0;
            for (int xx = 0; xx < 1024; xx++) begin
                if (cov[yy][xx]) begin
                    cnt++;
                    if (xx < mn) mn = xx;
                    if (xx > mx) mx = xx;
                end
            end
            checks++;
            if (yy >= 140 && yy <= 340) begin
                if (cnt == 0 || cnt != mx - mn + 1) begin
                    errors++;
                    $display("FAIL row_cover row %0d got %0d pixels over %0d..%0d required contiguous",
                             yy, cnt, mn, mx);
                end
            end else if (cnt != 0) begin
                errors++;
                $display("FAIL row_outside row %0d got %0d pixels required 0", yy, cnt);
            end
        end
        checks++;
        if (mn != mn || !cov[240][220] || !cov[240][420] || cov[240][219] || cov[240][421]) begin
            errors++;
            $display("FAIL row240_span got ends %0d/%0d outside %0d/%0d required 1/1 0/0",
                     cov[240][220], cov[240][420], cov[240][219], cov[240][421]);
        end

        // start held high: back-to-back identical draws
        done_cyc = -1;
        gap_en   = 1'b1;
        model_circle(200, 100, 5, 9, 8, 7);
        @(negedge clk);
        xC = 10'd200; yC = 9'd100; rad = 10'd5;
        r_i = 8'd9; g_i = 8'd8; b_i = 8'd7;
        start = 1'b1;
        wait_done("b2b_first", 1, 1'b0);
        model_circle(200, 100, 5, 9, 8, 7);
        wait_done("b2b_second", 1, 1'b0);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        gap_en = 1'b0;

        // reset in the middle of a draw, then a clean redraw
        model_circle(300, 200, 50, 40, 50, 60);
        start_draw(300, 200, 50, 40, 50, 60);
        repeat (30) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_zero("reset_middraw");
        exp_q.delete();
        @(negedge clk);
        check_zero("reset_held");
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("idle_after_middraw_reset");
        model_circle(300, 200, 50, 40, 50, 60);
        start_draw(300, 200, 50, 40, 50, 60);
        wait_done("after_reset", 1, 1'b0);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
